// File: rtl/core_mem_loader.sv
// core_mem_loader: streams activations into x_bank and kernels into w_bank
// through the core's unified memory port, hands over to the core, then reads
// back the output feature map and presents it as a valid-strobed stream.
module core_mem_loader #(
  parameter int bw         = 4,
  parameter int row        = 8,
  parameter int col        = 8,
  parameter int psum_bw    = 16,
  parameter int addr_width = 8,
  parameter int len_nij    = 36,
  parameter int len_kij    = 9,
  parameter int len_onij   = 16,
  parameter int rd_lat     = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [bw*row-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [addr_width-1:0]    ADDR,
  output logic                     ibank_selection,
  output logic                     CEN,
  output logic                     WEN,
  output logic [bw*row-1:0]        mem_d,
  output logic                     mem_load_complete,
  input  logic                     convolution_complete,
  input  logic [psum_bw*col-1:0]   core_q,
  output logic [psum_bw*col-1:0]   out_data,
  output logic                     out_valid,
  output logic [addr_width-1:0]    out_idx,
  output logic                     busy,
  output logic                     done
);

  localparam logic [addr_width-1:0] LAST_X = addr_width'(len_nij - 1);
  localparam logic [addr_width-1:0] LAST_W = addr_width'(len_kij * row - 1);
  localparam logic [addr_width-1:0] LAST_O = addr_width'(len_onij - 1);

  typedef enum logic [2:0] {IDLE, ACT, WGT, WAIT, READ, DRAIN} state_t;

  state_t                  state, state_nx;
  logic [addr_width-1:0]   cnt, cnt_nx;
  logic                    cc_prev;
  logic                    cc_rise;

  logic                    cmd_cen, cmd_wen, cmd_bank;
  logic [addr_width-1:0]   cmd_addr;
  logic [bw*row-1:0]       cmd_d;
  logic                    rd_issue;
  logic                    fin;

  logic [rd_lat-1:0]       tag_v;
  logic [addr_width-1:0]   tag_idx [rd_lat];

  assign cc_rise = convolution_complete & ~cc_prev;
  assign busy    = (state != IDLE);

  // Next-state, counter and next memory command
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    in_ready = 1'b0;
    cmd_cen  = 1'b1;
    cmd_wen  = 1'b1;
    cmd_bank = 1'b0;
    cmd_addr = '0;
    cmd_d    = '0;
    rd_issue = 1'b0;
    fin      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = ACT;
          cnt_nx   = '0;
        end
      end
      ACT, WGT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          cmd_cen  = 1'b0;
          cmd_wen  = 1'b0;
          cmd_bank = (state == WGT);
          cmd_addr = cnt;
          cmd_d    = in_data;
          if (state == ACT && cnt == LAST_X) begin
            state_nx = WGT;
            cnt_nx   = '0;
          end else if (state == WGT && cnt == LAST_W) begin
            state_nx = WAIT;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      WAIT: begin
        if (cc_rise) begin
          state_nx = READ;
          cnt_nx   = '0;
        end
      end
      READ: begin
        cmd_cen  = 1'b0;
        cmd_addr = cnt;
        rd_issue = 1'b1;
        if (cnt == LAST_O) begin
          state_nx = DRAIN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (tag_v == '0) begin
          fin      = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and word counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Registered memory port
  always_ff @(posedge clk) begin
    if (!reset) begin
      ADDR            <= '0;
      ibank_selection <= 1'b0;
      CEN             <= 1'b1;
      WEN             <= 1'b1;
      mem_d           <= '0;
    end else begin
      ADDR            <= cmd_addr;
      ibank_selection <= cmd_bank;
      CEN             <= cmd_cen;
      WEN             <= cmd_wen;
      mem_d           <= cmd_d;
    end
  end

  // Edge detector on convolution_complete, tracked in every state
  always_ff @(posedge clk) begin
    if (!reset) cc_prev <= 1'b0;
    else        cc_prev <= convolution_complete;
  end

  // Handshake flags: load-complete level and end-of-job pulse
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_load_complete <= 1'b0;
      done              <= 1'b0;
    end else begin
      done <= fin;
      if (fin)                mem_load_complete <= 1'b0;
      else if (state == WAIT) mem_load_complete <= 1'b1;
    end
  end

  // Read tag pipeline aligning each index with its returned core word
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < rd_lat; i++) begin
        tag_v[i]   <= 1'b0;
        tag_idx[i] <= '0;
      end
    end else begin
      tag_v[0]   <= rd_issue;
      tag_idx[0] <= cnt;
      for (int unsigned i = 1; i < rd_lat; i++) begin
        tag_v[i]   <= tag_v[i-1];
        tag_idx[i] <= tag_idx[i-1];
      end
    end
  end

  // Output capture at the tail of the tag pipeline
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
    end else begin
      out_valid <= tag_v[rd_lat-1];
      if (tag_v[rd_lat-1]) begin
        out_idx  <= tag_idx[rd_lat-1];
        out_data <= core_q;
      end
    end
  end

endmodule

// File: tb/tb_core_mem_loader.sv
// Bench for core_mem_loader: two instances (read latency 2 and 1) share one
// randomized stimulus stream and are compared every cycle against a
// transaction-level model of the load / convolve / readout job.
module tb_core_mem_loader;

  localparam int LEN_NIJ  = 36;
  localparam int LEN_W    = 72;
  localparam int TOTAL    = LEN_NIJ + LEN_W;
  localparam int LEN_ONIJ = 16;

  logic clk = 1'b0;
  logic reset, start, in_valid, cc;
  logic [31:0] in_data;

  logic         in_ready1, bank1, cen1, wen1, mlc1, ov1, busy1, done1;
  logic [7:0]   addr1, idx1;
  logic [31:0]  d1;
  logic [127:0] q1, od1;
  logic         in_ready2, bank2, cen2, wen2, mlc2, ov2, busy2, done2;
  logic [7:0]   addr2, idx2;
  logic [31:0]  d2;
  logic [127:0] q2, od2;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  core_mem_loader #(.rd_lat(2)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready1), .ADDR(addr1), .ibank_selection(bank1), .CEN(cen1), .WEN(wen1),
    .mem_d(d1), .mem_load_complete(mlc1), .convolution_complete(cc), .core_q(q1),
    .out_data(od1), .out_valid(ov1), .out_idx(idx1), .busy(busy1), .done(done1));

  core_mem_loader #(.rd_lat(1)) u_dut2 (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready2), .ADDR(addr2), .ibank_selection(bank2), .CEN(cen2), .WEN(wen2),
    .mem_d(d2), .mem_load_complete(mlc2), .convolution_complete(cc), .core_q(q2),
    .out_data(od2), .out_valid(ov2), .out_idx(idx2), .busy(busy2), .done(done2));

  // Output memory contents of the stand-in core
  function automatic logic [127:0] core_val(input int a);
    logic [31:0] h;
    h = 32'h9E37_79B9 * 32'(a + 7);
    return {h, ~h, h ^ 32'h5A5A_5A5A, h + 32'd1};
  endfunction

  // Core stand-ins: registered read (latency 2 build) and combinational read
  always @(posedge clk) if (!cen1 && wen1) q1 <= core_val(int'(addr1));
  assign q2 = core_val(int'(addr2));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {int at; int idx;} ev_t;
  ev_t oq1[$], oq2[$];
  int  cyc = 0;
  bit  m_active = 0, m_conv = 0, m_mlc = 0, m_cc_prev = 0;
  int  m_acc = 0, m_reads = 0, m_done_cyc = 0, m_done2_cyc = 0;

  logic         e_cen = 1, e_wen = 1, e_bank = 0, e_ready = 0, e_busy = 0, e_done = 0, e_ov = 0;
  logic [7:0]   e_addr = '0, e_idx = '0, e2_idx = '0;
  logic [31:0]  e_d = '0;
  logic [127:0] e_od = '0, e2_od = '0;
  logic         e2_ov = 0, e2_done = 0;

  task automatic model_step();
    cyc++;
    e_cen = 1; e_wen = 1; e_addr = '0; e_bank = 0; e_d = '0;
    e_done = 0; e_ov = 0; e2_done = 0; e2_ov = 0;
    if (!reset) begin
      m_active = 0; m_acc = 0; m_reads = 0; m_conv = 0; m_mlc = 0; m_cc_prev = 0;
      m_done_cyc = 0; m_done2_cyc = 0;
      oq1.delete(); oq2.delete();
      e_od = '0; e_idx = '0; e2_od = '0; e2_idx = '0;
    end else begin
      if (oq1.size() > 0 && oq1[0].at == cyc) begin
        e_ov = 1; e_idx = 8'(oq1[0].idx); e_od = core_val(oq1[0].idx);
        void'(oq1.pop_front());
      end
      if (oq2.size() > 0 && oq2[0].at == cyc) begin
        e2_ov = 1; e2_idx = 8'(oq2[0].idx); e2_od = core_val(oq2[0].idx);
        void'(oq2.pop_front());
      end
      if (m_done2_cyc == cyc) e2_done = 1;
      if (m_active && m_done_cyc == cyc) begin
        e_done = 1; m_active = 0; m_mlc = 0;
      end else if (!m_active) begin
        if (start) begin m_active = 1; m_acc = 0; m_reads = 0; m_conv = 0; end
      end else if (m_acc < TOTAL) begin
        if (in_valid) begin
          e_cen = 0; e_wen = 0; e_bank = (m_acc >= LEN_NIJ);
          e_addr = 8'(e_bank ? m_acc - LEN_NIJ : m_acc);
          e_d = in_data;
          m_acc++;
        end
      end else if (!m_conv) begin
        m_mlc = 1;
        if (cc && !m_cc_prev) m_conv = 1;
      end else if (m_reads < LEN_ONIJ) begin
        e_cen = 0; e_addr = 8'(m_reads);
        oq1.push_back('{cyc + 2, m_reads});
        oq2.push_back('{cyc + 1, m_reads});
        m_reads++;
        if (m_reads == LEN_ONIJ) begin m_done_cyc = cyc + 3; m_done2_cyc = cyc + 2; end
      end
      m_cc_prev = cc;
    end
    e_ready = m_active && (m_acc < TOTAL);
    e_busy  = m_active;
  endtask

  always begin
    @(posedge clk);
    model_step();
  end

  // ---------------- per-cycle comparison ----------------
  int done_cnt = 0, ov_cnt = 0, ov_cnt2 = 0;

  always begin
    @(negedge clk);
    if (cyc > 0) begin
      chk("cen", cen1, e_cen);
      chk("wen", wen1, e_wen);
      chk("addr", addr1, e_addr);
      chk("bank", bank1, e_bank);
      chk("mem_d", d1, e_d);
      chk("in_ready", in_ready1, e_ready);
      chk("mlc", mlc1, m_mlc);
      chk("busy", busy1, e_busy);
      chk("done", done1, e_done);
      chk("out_valid", ov1, e_ov);
      chk("out_idx", idx1, e_idx);
      chk("out_data", od1, e_od);
      chk("l1_cen", cen2, e_cen);
      chk("l1_addr", addr2, e_addr);
      chk("l1_wen", wen2, e_wen);
      chk("l1_out_valid", ov2, e2_ov);
      chk("l1_out_idx", idx2, e2_idx);
      chk("l1_out_data", od2, e2_od);
      chk("l1_done", done2, e2_done);
      if (done1) done_cnt++;
      if (ov1)   ov_cnt++;
      if (ov2)   ov_cnt2++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  // mode 0: in_valid held high, 1: pattern 1,0,0, 2: random
  task automatic feed(input int mode, input bit start_mid);
    int k = 0;
    while (m_acc < TOTAL && k < 1000) begin
      in_valid = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 3 == 0) : ($urandom_range(0, 3) != 0);
      in_data  = $urandom;
      start    = start_mid && (m_acc == 50);
      step();
      k++;
    end
    in_valid = 0; start = 0;
    if (m_acc < TOTAL) chk("feed_timeout", 0, 1);
  endtask

  task automatic pulse_cc();
    cc = 0; step();
    cc = 1; step();
    cc = 0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (m_active && k < 300) begin step(); k++; end
    if (m_active) chk("idle_timeout", 0, 1);
    repeat (3) step();
  endtask

  task automatic job_begin();
    done_cnt = 0; ov_cnt = 0; ov_cnt2 = 0;
    start = 1; step(); start = 0;
  endtask

  task automatic job_end_checks();
    chk("job_done_cnt", done_cnt, 1);
    chk("job_ov_cnt", ov_cnt, LEN_ONIJ);
    chk("job_l1_ov_cnt", ov_cnt2, LEN_ONIJ);
  endtask

  initial begin
    int k;
    reset = 0; start = 0; in_valid = 0; in_data = '0; cc = 0;
    repeat (3) step();
    reset = 1;
    step();

    // full job, continuous input
    job_begin();
    feed(0, 0);
    pulse_cc();
    wait_idle();
    job_end_checks();

    // stalled input with convolution_complete already high during load
    cc = 1;
    job_begin();
    feed(1, 0);
    repeat (4) step();
    pulse_cc();
    wait_idle();
    job_end_checks();

    // random input, start pulses while busy, in_valid during WAIT
    job_begin();
    feed(2, 1);
    in_valid = 1; in_data = $urandom;
    repeat (3) step();
    in_valid = 0;
    pulse_cc();
    k = 0;
    while (m_reads < 8 && k < 50) begin step(); k++; end
    start = 1; step(); start = 0;
    wait_idle();
    job_end_checks();

    // reset after the fifth read command
    job_begin();
    feed(2, 0);
    pulse_cc();
    k = 0;
    while (m_reads < 5 && k < 50) begin step(); k++; end
    chk("reads_before_reset", m_reads, 5);
    done_cnt = 0;
    reset = 0; step(); reset = 1;
    ov_cnt = 0; ov_cnt2 = 0;
    repeat (12) step();
    chk("post_reset_done", done_cnt, 0);
    chk("post_reset_ov", ov_cnt, 0);
    chk("post_reset_l1_ov", ov_cnt2, 0);

    // recovery job after the abort
    job_begin();
    feed(0, 0);
    pulse_cc();
    wait_idle();
    job_end_checks();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
